core_if_ras: RTL and testbench
==============================

# core_if_ras

Parametrised return-address stack for the fetch stage. It holds predicted return targets: jal/jalr predictions push, jr predictions pop. It also accepts the decode-stage repair commands (recover_push, recover_push_addr, recover_pop) that undo a speculative push or pop once decode finds the BTB type was wrong. It is a circular buffer with configurable depth and address width, overflow-by-overwrite, underflow reporting and a flush.

## Interface
- DEPTH, 8: number of entries; power of two, ≥2. Derived PTR_W = log2(DEPTH).
- AW, 32: return-address width.
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset. Asserting it (low) clears all state immediately; release is synchronous to clk.
- flush  in  1  clears the stack (pipeline redirect from a non-recoverable event).
- push  in  1  speculative push from fetch (jal/jalr predicted).
- push_addr  in  AW  address to push (PC+4 of the call).
- pop  in  1  speculative pop from fetch (jr predicted).
- recover_push  in  1  decode repair: re-insert an entry wrongly popped.
- recover_push_addr  in  AW  address to re-insert.
- recover_pop  in  1  decode repair: remove an entry wrongly pushed.
- top_addr  out  AW  mem[tos]; 0 when empty.
- top_valid  out  1  count != 0.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky; set when a push overwrote the oldest entry; cleared by flush or reset.
- udf  out  1  one-cycle pulse, registered; a pop or recover_pop hit an empty stack.

## Operation
- State: mem[0..DEPTH-1] (AW bits each), tos pointer (PTR_W), count (PTR_W+1), ovf, udf.
- Primitive PUSH(a): tos ← tos+1 mod DEPTH; mem[new tos] ← a; count ← min(count+1, DEPTH). If count was DEPTH, set ovf; the oldest entry is lost (wrap-around).
- Primitive POP: if count>0, tos ← tos−1 mod DEPTH and count ← count−1; entry contents are left in place. If count=0, there is no state change and udf pulses.
- Per-cycle order, evaluated on intermediate state within one cycle:
  1. flush: tos=0, count=0, ovf=0. Discards all other requests this cycle.
  2. Repair: recover_pop has priority; if both recover_* are high, recover_push is ignored. recover_pop performs POP. recover_push performs PUSH(recover_push_addr).
  3. Fetch op: push&&pop performs POP then PUSH(push_addr). When non-empty this replaces the top in place with no count change. When empty, it gives count=1 with udf pulsed. push alone performs PUSH. pop alone performs POP.
- udf is high the cycle after any POP that found the intermediate count at 0, from either stage.
- A fetch op that follows a repair in the same cycle sees the repaired state. Example: count=2, recover_pop + push(A) gives count=2 with top=A.
- top_addr and top_valid reflect registered state only; there is no bypass of same-cycle writes.

## Timing
- Reset values: tos=0, count=0, all mem entries 0, ovf=0, udf=0, top_addr=0, top_valid=0.
- Asynchronous reset applies mid-operation without waiting for a clock edge. Requests present at the first edge after release are processed normally.
- Latency is 1 cycle: a request at edge N is visible on top_addr, count and ovf after edge N.
- There is no handshake. Every request is accepted every cycle, and back-to-back ops are allowed indefinitely.
- Pointer arithmetic wraps modulo DEPTH.
- count saturates at DEPTH on push and never goes below 0.

## Test plan
- Reset/basic (DEPTH=8): push 0x100, 0x200, 0x300 over 3 cycles -> count=3, top=0x300. Pop ×3 -> tops 0x200, 0x100, then top_valid=0, count=0, no udf.
- Overflow wrap: push 0x10..0x19 (10 pushes) -> count=8, ovf=1. Pops return 0x19 down to 0x12, then empty. A 9th pop gives a udf pulse, count stays 0.
- Simultaneous fetch ops: stack [0xA,0xB], push 0xC with pop -> count=2, top=0xC. On an empty stack, push 0xD with pop -> count=1, top=0xD, udf=1 for one cycle.
- Repair + fetch: stack [0xA], recover_push 0xB with pop in the same cycle -> count=1, top=0xA. recover_pop + recover_push -> only the pop takes effect. recover_pop on empty -> udf pulse.
- Flush: stack full with ovf=1, flush asserted together with push 0xE -> count=0, ovf=0, top_valid=0 next cycle; the push is discarded.
- Async reset: drop rst between clock edges while count=5 -> outputs go to their reset values before the next edge. Release and push 0x40 -> count=1, top=0x40.

Source files
------------

// File: rtl/core_if_ras.sv
// ---------------------------------------------------------------------------
// core_if_ras
//
// Return-address stack for the fetch stage. Predicted calls (jal/jalr) push
// their return address and predicted returns (jr) pop it. Decode can repair
// a wrong speculative push or pop in the same cycle through the recover_*
// commands. The stack is a circular buffer. A push onto a full stack
// overwrites the oldest entry and sets a sticky overflow flag. A pop from an
// empty stack pulses an underflow flag for one cycle.
//
// Parameters
//   DEPTH              number of entries, power of two, at least 2
//   AW                 return-address width
//
// Ports
//   clk                core clock, all state updates on the rising edge
//   rst                asynchronous active-low reset, clears all state
//   flush              empties the stack and clears ovf, drops other requests
//   push               speculative push of push_addr from fetch
//   push_addr          return address to push
//   pop                speculative pop from fetch
//   recover_push       decode repair, re-insert recover_push_addr
//   recover_push_addr  address to re-insert
//   recover_pop        decode repair, remove the top entry (beats recover_push)
//   top_addr           entry at the top of the stack, 0 when empty
//   top_valid          stack is non-empty
//   count              current occupancy, 0..DEPTH
//   ovf                sticky, a push overwrote the oldest entry
//   udf                one-cycle registered pulse, a pop found the stack empty
// ---------------------------------------------------------------------------
module core_if_ras #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [AW-1:0]            push_addr,
    input  logic                     pop,
    input  logic                     recover_push,
    input  logic [AW-1:0]            recover_push_addr,
    input  logic                     recover_pop,
    output logic [AW-1:0]            top_addr,
    output logic                     top_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     udf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Registered state
    logic [AW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] tos_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             udf_q;

    // Next-state values and the (at most two) entry writes of this cycle
    logic [PTR_W-1:0] tos_n;
    logic [CNT_W-1:0] count_n;
    logic             ovf_n;
    logic             udf_n;
    logic             wr_rep;
    logic [PTR_W-1:0] wr_rep_idx;
    logic             wr_fetch;
    logic [PTR_W-1:0] wr_fetch_idx;

    // Next-state evaluation. The repair stage runs first and the fetch stage
    // then works on the repaired pointer and count, so both stages chain
    // through the same tos_n/count_n variables. Within the fetch stage the
    // pop is applied before the push. Together with a push this replaces the
    // top entry in place, or on an empty stack leaves one entry and reports
    // the underflow. A popped entry is never cleared. Only the pointer moves.
    always_comb begin
        tos_n        = tos_q;
        count_n      = count_q;
        ovf_n        = ovf_q;
        udf_n        = 1'b0;
        wr_rep       = 1'b0;
        wr_rep_idx   = '0;
        wr_fetch     = 1'b0;
        wr_fetch_idx = '0;

        if (flush) begin
            tos_n   = '0;
            count_n = '0;
            ovf_n   = 1'b0;
        end else begin
            if (recover_pop) begin
                if (count_n != '0) begin
                    tos_n   = tos_n - PTR_ONE;
                    count_n = count_n - CNT_ONE;
                end else begin
                    udf_n = 1'b1;
                end
            end else if (recover_push) begin
                tos_n      = tos_n + PTR_ONE;
                wr_rep     = 1'b1;
                wr_rep_idx = tos_n;
                if (count_n == CNT_FULL) begin
                    ovf_n = 1'b1;
                end else begin
                    count_n = count_n + CNT_ONE;
                end
            end

            if (pop) begin
                if (count_n != '0) begin
                    tos_n   = tos_n - PTR_ONE;
                    count_n = count_n - CNT_ONE;
                end else begin
                    udf_n = 1'b1;
                end
            end

            if (push) begin
                tos_n        = tos_n + PTR_ONE;
                wr_fetch     = 1'b1;
                wr_fetch_idx = tos_n;
                if (count_n == CNT_FULL) begin
                    ovf_n = 1'b1;
                end else begin
                    count_n = count_n + CNT_ONE;
                end
            end
        end
    end

    // State registers. When the repair and fetch writes target the same
    // entry (recover_push followed by push with pop), the fetch write is
    // issued last and therefore wins, which matches the in-cycle ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            tos_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_n;
            count_q <= count_n;
            ovf_q   <= ovf_n;
            udf_q   <= udf_n;
            if (wr_rep) begin
                mem[wr_rep_idx] <= recover_push_addr;
            end
            if (wr_fetch) begin
                mem[wr_fetch_idx] <= push_addr;
            end
        end
    end

    // Outputs come from registered state only. Same-cycle writes are not
    // bypassed.
    assign top_valid = (count_q != '0);
    assign top_addr  = top_valid ? mem[tos_q] : '0;
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;

endmodule

// File: tb/tb_core_if_ras.sv
// ---------------------------------------------------------------------------
// tb_core_if_ras
//
// Self-checking bench for core_if_ras (DEPTH=8, AW=32). The reference model
// is a queue of return addresses with the newest entry at the back. A push
// onto a full queue drops the front entry. Directed steps follow the test
// plan, and a randomized phase follows them. Every cycle compares top_addr,
// top_valid, count, ovf and udf against the model.
// ---------------------------------------------------------------------------
module tb_core_if_ras;

    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk;
    logic             rst;
    logic             flush;
    logic             push;
    logic [AW-1:0]    push_addr;
    logic             pop;
    logic             recover_push;
    logic [AW-1:0]    recover_push_addr;
    logic             recover_pop;
    logic [AW-1:0]    top_addr;
    logic             top_valid;
    logic [PTR_W:0]   count;
    logic             ovf;
    logic             udf;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [AW-1:0] q[$];
    logic          exp_ovf;
    logic          exp_udf;

    core_if_ras #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .push              (push),
        .push_addr         (push_addr),
        .pop               (pop),
        .recover_push      (recover_push),
        .recover_push_addr (recover_push_addr),
        .recover_pop       (recover_pop),
        .top_addr          (top_addr),
        .top_valid         (top_valid),
        .count             (count),
        .ovf               (ovf),
        .udf               (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison, counted and reported through an immediate assertion
    task automatic check_val(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
    endtask

    task automatic model_push(input logic [AW-1:0] a);
        if (q.size() == DEPTH) begin
            void'(q.pop_front());
            exp_ovf = 1'b1;
        end
        q.push_back(a);
    endtask

    task automatic model_pop();
        if (q.size() == 0) begin
            exp_udf = 1'b1;
        end else begin
            void'(q.pop_back());
        end
    endtask

    // Applies the per-cycle request rules to the queue model
    task automatic model_step(input logic f, input logic p, input logic [AW-1:0] pa,
                              input logic po, input logic rp, input logic [AW-1:0] rpa,
                              input logic rpo);
        exp_udf = 1'b0;
        if (f) begin
            q.delete();
            exp_ovf = 1'b0;
        end else begin
            if (rpo) begin
                model_pop();
            end else if (rp) begin
                model_push(rpa);
            end
            if (p && po) begin
                model_pop();
                model_push(pa);
            end else if (p) begin
                model_push(pa);
            end else if (po) begin
                model_pop();
            end
        end
    endtask

    task automatic check_output(input string tag);
        logic [AW-1:0] exp_top;
        exp_top = (q.size() != 0) ? q[$] : '0;
        check_val({tag, ".count"},     64'(count),     64'(q.size()));
        check_val({tag, ".top_valid"}, 64'(top_valid), 64'(q.size() != 0));
        check_val({tag, ".top_addr"},  64'(top_addr),  64'(exp_top));
        check_val({tag, ".ovf"},       64'(ovf),       64'(exp_ovf));
        check_val({tag, ".udf"},       64'(udf),       64'(exp_udf));
    endtask

    // Drives one cycle of requests, updates the model at the edge and checks
    // the outputs 1 ns after it. The inputs then return to idle.
    task automatic apply_stimulus(input string tag, input logic f, input logic p,
                                  input logic [AW-1:0] pa, input logic po,
                                  input logic rp, input logic [AW-1:0] rpa,
                                  input logic rpo);
        @(negedge clk);
        flush             = f;
        push              = p;
        push_addr         = pa;
        pop               = po;
        recover_push      = rp;
        recover_push_addr = rpa;
        recover_pop       = rpo;
        @(posedge clk);
        model_step(f, p, pa, po, rp, rpa, rpo);
        #1;
        check_output(tag);
        flush        = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        recover_push = 1'b0;
        recover_pop  = 1'b0;
    endtask

    task automatic do_push(input string tag, input logic [AW-1:0] a);
        apply_stimulus(tag, 1'b0, 1'b1, a, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_pop(input string tag);
        apply_stimulus(tag, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic do_idle(input string tag);
        apply_stimulus(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst               = 1'b0;
        flush             = 1'b0;
        push              = 1'b0;
        push_addr         = '0;
        pop               = 1'b0;
        recover_push      = 1'b0;
        recover_push_addr = '0;
        recover_pop       = 1'b0;
        model_reset();

        // Reset state
        #12;
        check_output("reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic push/pop
        do_push("basic_push", 32'h100);
        do_push("basic_push", 32'h200);
        do_push("basic_push", 32'h300);
        check_val("basic_count3", 64'(count), 64'd3);
        check_val("basic_top300", 64'(top_addr), 64'h300);
        do_pop("basic_pop");
        check_val("basic_top200", 64'(top_addr), 64'h200);
        do_pop("basic_pop");
        do_pop("basic_pop");
        check_val("basic_empty_udf", 64'(udf), 64'd0);

        // Overflow wrap
        for (int i = 0; i < 10; i++) begin
            do_push("ovf_push", 32'h10 + 32'(i));
        end
        check_val("ovf_count8", 64'(count), 64'd8);
        check_val("ovf_flag", 64'(ovf), 64'd1);
        for (int i = 0; i < 8; i++) begin
            do_pop("ovf_pop");
        end
        do_pop("ovf_pop9");
        check_val("ovf_udf_pulse", 64'(udf), 64'd1);
        do_idle("ovf_udf_drop");
        check_val("ovf_udf_low", 64'(udf), 64'd0);

        // Simultaneous fetch push and pop
        apply_stimulus("clr", 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        do_push("sim_push", 32'hA);
        do_push("sim_push", 32'hB);
        apply_stimulus("sim_pp_full", 1'b0, 1'b1, 32'hC, 1'b1, 1'b0, '0, 1'b0);
        check_val("sim_topC", 64'(top_addr), 64'hC);
        do_pop("sim_pop");
        do_pop("sim_pop");
        apply_stimulus("sim_pp_empty", 1'b0, 1'b1, 32'hD, 1'b1, 1'b0, '0, 1'b0);
        check_val("sim_empty_udf", 64'(udf), 64'd1);
        do_idle("sim_idle");

        // Repair combined with fetch
        do_pop("rep_pop");
        do_push("rep_push", 32'hA);
        apply_stimulus("rep_rpush_pop", 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hB, 1'b0);
        check_val("rep_topA", 64'(top_addr), 64'hA);
        do_push("rep_push", 32'h55);
        apply_stimulus("rep_both", 1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h77, 1'b1);
        apply_stimulus("rep_rpop_push", 1'b0, 1'b1, 32'h66, 1'b0, 1'b0, '0, 1'b1);
        apply_stimulus("rep_rpush_pp", 1'b0, 1'b1, 32'h99, 1'b1, 1'b1, 32'h88, 1'b0);
        apply_stimulus("rep_rpop", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        apply_stimulus("rep_rpop", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        apply_stimulus("rep_rpop_empty", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        check_val("rep_udf", 64'(udf), 64'd1);

        // Flush over a full, overflowed stack
        for (int i = 0; i < 9; i++) begin
            do_push("fl_push", 32'h1000 + 32'(i));
        end
        apply_stimulus("flush_push", 1'b1, 1'b1, 32'hE, 1'b0, 1'b0, '0, 1'b0);
        check_val("flush_count", 64'(count), 64'd0);
        check_val("flush_ovf", 64'(ovf), 64'd0);

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) begin
            do_push("ar_push", 32'h2000 + 32'(i));
        end
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_output("async_reset");
        @(negedge clk);
        rst = 1'b1;
        do_push("ar_release_push", 32'h40);
        check_val("ar_top40", 64'(top_addr), 64'h40);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            apply_stimulus("rand",
                           ($urandom_range(0, 39) == 0),
                           ($urandom_range(0, 1) == 1),
                           $urandom(),
                           ($urandom_range(0, 2) == 0),
                           ($urandom_range(0, 5) == 0),
                           $urandom(),
                           ($urandom_range(0, 5) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
